// File: rtl/mmio_arbiter.sv
// ---------------------------------------------------------------------------
// mmio_arbiter
//
// Shares one MMIO slave port between NUM_REQ requesters (for example the CPU
// core and the network DMA). One access is in flight at a time. A winner is
// accepted in IDLE with a combinational one-hot o_req_ready pulse. Its
// request then goes through ACCESS (one cycle of address/data, with the
// write strobe for writes). Reads pass through WAIT until the slave data is
// valid. RESP returns a one-cycle one-hot o_rsp_valid pulse.
//
// Parameters
//   MEMORY_BUS_WIDTH  data width W; MMIO word address is W-2 bits
//   NUM_REQ           number of requesters (2..4)
//   READ_LATENCY      cycles from address presented to i_mmio_rdata valid (1..7)
//
// Ports
//   i_clock        single clock, rising edge
//   i_reset        synchronous active-high reset
//   i_req_valid    per-requester request
//   i_req_write    per-requester 1 = write, 0 = read
//   i_req_addr     packed word addresses, requester i at slice i
//   i_req_data     packed write data
//   i_req_wb       packed 4-bit byte enables
//   o_req_ready    one-hot accept pulse (IDLE only)
//   o_rsp_valid    one-hot completion pulse
//   o_rsp_data     read data, shared by all requesters
//   o_busy         high whenever the FSM is not in IDLE
//   o_mmio_addr    MMIO word address
//   o_mmio_wdata   MMIO write data
//   o_mmio_wb      MMIO byte write enables, 0 = no write
//   i_mmio_rdata   MMIO read data
//
// Build option
//   MMIO_ARB_FIXED_PRIO_EN  when defined, the lowest valid index always wins
//                           (no round-robin state); default is round-robin.
// ---------------------------------------------------------------------------
module mmio_arbiter #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int NUM_REQ          = 2,
    parameter int READ_LATENCY     = 1
) (
    input  logic                                   i_clock,
    input  logic                                   i_reset,
    input  logic [NUM_REQ-1:0]                     i_req_valid,
    input  logic [NUM_REQ-1:0]                     i_req_write,
    input  logic [NUM_REQ*(MEMORY_BUS_WIDTH-2)-1:0] i_req_addr,
    input  logic [NUM_REQ*MEMORY_BUS_WIDTH-1:0]    i_req_data,
    input  logic [NUM_REQ*4-1:0]                   i_req_wb,
    output logic [NUM_REQ-1:0]                     o_req_ready,
    output logic [NUM_REQ-1:0]                     o_rsp_valid,
    output logic [MEMORY_BUS_WIDTH-1:0]            o_rsp_data,
    output logic                                   o_busy,
    output logic [MEMORY_BUS_WIDTH-3:0]            o_mmio_addr,
    output logic [MEMORY_BUS_WIDTH-1:0]            o_mmio_wdata,
    output logic [3:0]                             o_mmio_wb,
    input  logic [MEMORY_BUS_WIDTH-1:0]            i_mmio_rdata
);

    localparam int AW = MEMORY_BUS_WIDTH - 2;
    localparam int DW = MEMORY_BUS_WIDTH;
    localparam int GW = (NUM_REQ > 2) ? 2 : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]    r_state;
    logic [GW-1:0] r_grant;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [3:0]    r_wb;
    logic          r_write;
    logic [2:0]    r_cnt;
    logic [DW-1:0] r_rsp_data;
`ifndef MMIO_ARB_FIXED_PRIO_EN
    logic [GW-1:0] r_last_grant;
`endif

    logic          w_found;
    logic [GW-1:0] w_win;
    logic [GW-1:0] w_cand;
    logic          w_accept;

    logic [AW-1:0] w_addr_a [NUM_REQ];
    logic [DW-1:0] w_data_a [NUM_REQ];
    logic [3:0]    w_wb_a   [NUM_REQ];

    // Split the packed request buses into per-requester slices.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_a[gi] = i_req_addr[gi*AW +: AW];
        assign w_data_a[gi] = i_req_data[gi*DW +: DW];
        assign w_wb_a[gi]   = i_req_wb[gi*4 +: 4];
    end

    // Winner selection. Round-robin scans from the requester after the last
    // winner; the fixed-priority build keeps the lowest valid index.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
`ifdef MMIO_ARB_FIXED_PRIO_EN
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = GW'(k);
            if (i_req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = GW'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
`endif
    end

    // Accept is suppressed while reset is asserted so no requester sees a
    // ready for a request that the reset edge is about to discard.
    assign w_accept    = (r_state == S_IDLE) && w_found && !i_reset;
    assign o_req_ready = w_accept ? (NUM_REQ'(1) << w_win) : '0;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wb       <= '0;
            r_write    <= 1'b0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
`ifndef MMIO_ARB_FIXED_PRIO_EN
            r_last_grant <= GW'(NUM_REQ - 1);
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_ACCESS;
                        r_grant <= w_win;
                        r_addr  <= w_addr_a[w_win];
                        r_wdata <= w_data_a[w_win];
                        r_wb    <= w_wb_a[w_win];
                        r_write <= i_req_write[w_win];
`ifndef MMIO_ARB_FIXED_PRIO_EN
                        r_last_grant <= w_win;
`endif
                    end
                end
                S_ACCESS: begin
                    if (r_write) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt   <= 3'(READ_LATENCY);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // cnt reaches 1 in the cycle the slave data is valid.
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_rsp_data <= i_mmio_rdata;
                        r_state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Address and data come straight from the latched request so they hold
    // through IDLE and RESP; the strobe is confined to ACCESS of a write.
    assign o_mmio_addr  = r_addr;
    assign o_mmio_wdata = r_wdata;
    assign o_mmio_wb    = (r_state == S_ACCESS && r_write) ? r_wb : 4'd0;
    assign o_rsp_valid  = (r_state == S_RESP) ? (NUM_REQ'(1) << r_grant) : '0;
    assign o_rsp_data   = r_rsp_data;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mmio_arbiter.sv
module tb_mmio_arbiter;

    localparam int W  = 32;
    localparam int N  = 2;
    localparam int RL = 1;
    localparam int AW = W - 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_data;
    logic [N*4-1:0]  req_wb;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [W-1:0]    rsp_data;
    logic            busy;
    logic [AW-1:0]   mmio_addr;
    logic [W-1:0]    mmio_wdata;
    logic [3:0]      mmio_wb;
    logic [W-1:0]    mmio_rdata;

    always #5 clk = ~clk;

    mmio_arbiter #(.MEMORY_BUS_WIDTH(W), .NUM_REQ(N), .READ_LATENCY(RL)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_req_valid  (req_valid),
        .i_req_write  (req_write),
        .i_req_addr   (req_addr),
        .i_req_data   (req_data),
        .i_req_wb     (req_wb),
        .o_req_ready  (req_ready),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_data   (rsp_data),
        .o_busy       (busy),
        .o_mmio_addr  (mmio_addr),
        .o_mmio_wdata (mmio_wdata),
        .o_mmio_wb    (mmio_wb),
        .i_mmio_rdata (mmio_rdata)
    );

    function automatic logic [31:0] init_val(int i);
        if (i == 32'h40) return 32'h12345678;
        return {4{8'(i)}} ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (b[k]) r[k*8 +: 8] = d[k*8 +: 8];
        return r;
    endfunction

    // MMIO slave: 256-word memory, registered read data (one cycle latency).
    logic [31:0] s_mem [256];
    logic        s_init = 1'b0;
    always @(posedge clk) begin
        if (!s_init) begin
            for (int i = 0; i < 256; i++) s_mem[i] <= init_val(i);
            s_init     <= 1'b1;
            mmio_rdata <= '0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mmio_wb[b]) s_mem[mmio_addr[7:0]][b*8 +: 8] <= mmio_wdata[b*8 +: 8];
            mmio_rdata <= s_mem[mmio_addr[7:0]];
        end
    end

    // Requester state: 0 idle, 1 pending (valid high), 2 outstanding.
    int            rq_st [N];
    logic          rq_w  [N];
    logic [AW-1:0] rq_a  [N];
    logic [31:0]   rq_d  [N];
    logic [3:0]    rq_b  [N];

    // Transaction-level reference model.
    int            cyc;
    bit            m_busy;
    int            m_acc, m_done, m_g, m_last;
    bit            m_w;
    logic [3:0]    m_b;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wd, m_rd, m_rsp_data;
    logic [31:0]   m_mem [256];

    int n_cmp  = 0;
    int n_fail = 0;

    // Observations collected from the DUT for sequence checks.
    int acc_q [$];
    int gnt_q [$];
    int rsp_cyc;
    int n_rsp;
    logic [31:0] last_rsp;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy     = 1'b0;
        m_addr     = '0;
        m_wd       = '0;
        m_rsp_data = '0;
        m_last     = N - 1;
        m_acc      = -10;
        m_done     = -10;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = (rq_st[i] == 1);
            req_write[i]         = rq_w[i];
            req_addr[i*AW +: AW] = rq_a[i];
            req_data[i*W +: W]   = rq_d[i];
            req_wb[i*4 +: 4]     = rq_b[i];
        end
    endtask

    task automatic issue(int i, logic w, logic [AW-1:0] a, logic [31:0] d, logic [3:0] b);
        rq_st[i] = 1;
        rq_w[i]  = w;
        rq_a[i]  = a;
        rq_d[i]  = d;
        rq_b[i]  = b;
    endtask

    // kind: -1 random, 0 read, 1 write
    task automatic rand_issue(int i, int kind);
        logic w;
        logic [3:0] b;
        w = (kind < 0) ? 1'($urandom_range(0, 1)) : 1'(kind);
        b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        issue(i, w, AW'($urandom), $urandom, b);
    endtask

    // Idle requesters (or the one whose response is this cycle) may start.
    task automatic gen(int pct, logic [N-1:0] en, int kind);
        for (int i = 0; i < N; i++) begin
            if (en[i] && (rq_st[i] == 0 || (rq_st[i] == 2 && m_busy && m_g == i && cyc == m_done))
                && $urandom_range(0, 99) < pct)
                rand_issue(i, kind);
        end
    endtask

    task automatic pick(output int g, output bit have);
        have = 1'b0;
        g    = 0;
`ifdef MMIO_ARB_FIXED_PRIO_EN
        for (int k = N - 1; k >= 0; k--)
            if (rq_st[k] == 1) begin have = 1'b1; g = k; end
`else
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (!have && rq_st[c] == 1) begin have = 1'b1; g = c; end
        end
`endif
    endtask

    // One clock cycle: drive, sample on the falling edge, compare, advance model.
    task automatic cycle();
        logic [N-1:0] e_ready, e_rsp;
        logic [3:0]   e_wb;
        int g;
        bit have;
        drive();
        @(negedge clk);
        e_ready = '0;
        e_rsp   = '0;
        e_wb    = '0;
        have    = 1'b0;
        g       = 0;
        if (m_busy && cyc == m_done && !m_w) m_rsp_data = m_rd;
        if (m_busy && cyc == m_done) e_rsp = N'(1) << m_g;
        if (m_busy && cyc == m_acc + 1 && m_w) e_wb = m_b;
        if (!m_busy && !rst) begin
            pick(g, have);
            if (have) e_ready = N'(1) << g;
        end
        check("req_ready",  32'(req_ready),  32'(e_ready));
        check("rsp_valid",  32'(rsp_valid),  32'(e_rsp));
        check("rsp_data",   rsp_data,        m_rsp_data);
        check("busy",       32'(busy),       32'(m_busy));
        check("mmio_addr",  32'(mmio_addr),  32'(m_addr));
        check("mmio_wdata", mmio_wdata,      m_wd);
        check("mmio_wb",    32'(mmio_wb),    32'(e_wb));

        if (req_ready != '0) begin
            acc_q.push_back(cyc);
            for (int i = 0; i < N; i++) if (req_ready[i]) gnt_q.push_back(i);
        end
        if (rsp_valid != '0) begin
            rsp_cyc  = cyc;
            last_rsp = rsp_data;
            n_rsp++;
        end

        if (rst) begin
            model_reset();
            for (int i = 0; i < N; i++) if (rq_st[i] == 2) rq_st[i] = 0;
        end else if (m_busy && cyc == m_done) begin
            m_busy = 1'b0;
            if (rq_st[m_g] == 2) rq_st[m_g] = 0;
        end else if (have) begin
            m_busy = 1'b1;
            m_acc  = cyc;
            m_g    = g;
            m_w    = rq_w[g];
            m_b    = rq_b[g];
            m_done = cyc + (m_w ? 2 : 2 + RL);
            m_addr = rq_a[g];
            m_wd   = rq_d[g];
            m_last = g;
            if (m_w) m_mem[rq_a[g][7:0]] = merge(m_mem[rq_a[g][7:0]], rq_d[g], rq_b[g]);
            else     m_rd = m_mem[rq_a[g][7:0]];
            rq_st[g] = 2;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic int last_acc();
        if (acc_q.size() == 0) return -1000;
        return acc_q[acc_q.size() - 1];
    endfunction

    task automatic drain();
        for (int k = 0; k < 30; k++) begin
            if (!m_busy && rq_st[0] == 0 && rq_st[1] == 0) break;
            cycle();
        end
        check("drain_idle", 32'(m_busy || rq_st[0] != 0 || rq_st[1] != 0), 32'd0);
    endtask

    initial begin
        cyc = 0;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            rq_st[i] = 0; rq_w[i] = 1'b0; rq_a[i] = '0; rq_d[i] = '0; rq_b[i] = '0;
        end
        for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
        model_reset();
        n_rsp = 0;
        rsp_cyc = -1;
        last_rsp = '0;
        drive();
        @(posedge clk);
        #1;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        // Single write from requester 0.
        issue(0, 1'b1, 30'h0000100, 32'hDEADBEEF, 4'hF);
        repeat (4) cycle();
        check("wr_latency", 32'(rsp_cyc - last_acc()), 32'd2);
        check("wr_grant",   32'(gnt_q[gnt_q.size() - 1]), 32'd0);

        // Single read from requester 1; slave holds 0x12345678 at 0x40.
        issue(1, 1'b0, 30'h0000040, 32'h0, 4'h0);
        repeat (5) cycle();
        check("rd_latency", 32'(rsp_cyc - last_acc()), 32'd3);
        check("rd_value",   last_rsp, 32'h12345678);

        // Contention: both valid while reset is high, then released.
        issue(0, 1'b1, 30'h0000010, 32'h01010101, 4'h3);
        issue(1, 1'b1, 30'h0000020, 32'h02020202, 4'hC);
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        gnt_q.delete();
        for (int k = 0; k < 16; k++) begin
            gen(100, 2'b11, 1);
            cycle();
        end
        for (int j = 0; j < 4; j++) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
            check("grant_seq", (gnt_q.size() > j) ? 32'(gnt_q[j]) : 32'hFFFF_FFFF, 32'd0);
`else
            check("grant_seq", (gnt_q.size() > j) ? 32'(gnt_q[j]) : 32'hFFFF_FFFF, 32'(j % 2));
`endif
        end
        drain();

        // Back-to-back writes from requester 0 reasserting in its response cycle.
        acc_q.delete();
        issue(0, 1'b1, 30'h0000030, 32'hCAFEF00D, 4'hF);
        for (int k = 0; k < 7; k++) begin
            gen(100, 2'b01, 1);
            cycle();
        end
        check("b2b_gap", (acc_q.size() > 1) ? 32'(acc_q[1] - acc_q[0]) : 32'hFFFF_FFFF, 32'd3);
        drain();

        // Reset pulsed during WAIT of a read: no response, everything cleared.
        n_rsp = 0;
        issue(1, 1'b0, 30'h0000040, 32'h0, 4'h0);
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rdata", rsp_data, 32'd0);
        repeat (5) cycle();
        check("abort_no_rsp", 32'(n_rsp), 32'd0);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            gen(35, 2'b11, -1);
            cycle();
        end
        rst = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Shares a single MMIO slave port (word address, write data, 4-bit byte write-enable, read data) between NUM_REQ requesters, e.g. the CPU core and the network-interface DMA. It arbitrates round-robin, serialises one access at a time, drives the MMIO signals with correct write-pulse and read-latency timing, and returns a one-cycle response to the winner. It sits between the requesters' memory ports and the MMIO peripheral decode.

## Interface
- MEMORY_BUS_WIDTH, 32, data width W; MMIO word address is W-2 bits.
- NUM_REQ, 2, number of requesters (2..4).
- READ_LATENCY, 1, cycles from address presented to mmio_rdata valid (1..7).

- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*(W-2)  word addresses, requester i at slice i.
- req_data  in  NUM_REQ*W  write data.
- req_wb  in  NUM_REQ*4  byte enables; writes must be nonzero.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_data  out  W  read data, shared by all requesters.
- busy  out  1  high when the FSM is not in IDLE.
- mmio_addr  out  W-2  to the MMIO addr_in.
- mmio_wdata  out  W  to the MMIO data_in.
- mmio_wb  out  4  to the MMIO wb_in; 0 = no write.
- mmio_rdata  in  W  from the MMIO data_out.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any req_valid, pick winner g round-robin starting at (last_grant+1) mod NUM_REQ. Assert req_ready[g] combinationally in the same cycle. Latch addr, data, wb and write of g, set last_grant=g, go to ACCESS. Otherwise stay in IDLE.
- ACCESS: drive mmio_addr and mmio_wdata from the latched request.
  - Write: mmio_wb = latched wb for this cycle only, then go to RESP.
  - Read: mmio_wb = 0, load cnt = READ_LATENCY, then go to WAIT.
- WAIT (reads only): hold mmio_addr, mmio_wb = 0, decrement cnt each cycle. When cnt==1, register mmio_rdata into rsp_data and go to RESP.
- RESP: rsp_valid[g]=1 for one cycle, mmio_wb=0, then go to IDLE. req_ready stays 0 outside IDLE.
- rsp_data changes only on read completion. Writes leave it unchanged.
- mmio_addr and mmio_wdata hold their last values in IDLE and RESP. mmio_wb is nonzero only in ACCESS of a write.
- Requester rules:
  - Hold req_valid and its payload stable until req_ready.
  - At most one outstanding request per requester.
  - May reassert req_valid in the cycle its rsp_valid is asserted.
- A request with req_write=1 and req_wb=0 is still executed: a one-cycle ACCESS with no MMIO effect, followed by RESP.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, busy=0, mmio_addr=0, mmio_wdata=0, mmio_wb=0, state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), cnt=0.
- Accept at cycle t. Write: ACCESS at t+1, rsp_valid at t+2, next accept at t+3 at the earliest (3-cycle write).
- Read: ACCESS at t+1, WAIT from t+2 to t+1+READ_LATENCY, rsp_valid at t+2+READ_LATENCY. With READ_LATENCY=1 a read takes 4 cycles.
- Simultaneous requests: only one req_ready per IDLE cycle. Losers keep req_valid high and are served in later rounds. A requester is never starved beyond NUM_REQ-1 other accesses.
- Reset mid-operation (any state): on the next edge all registers return to reset values. The access is aborted with no rsp_valid, and mmio_wb is 0 from the following cycle. Requesters must reissue.
- Reset while req_valid is high: no req_ready while reset is high.

## Configuration
- MMIO_ARB_FIXED_PRIO_EN defined: fixed priority replaces round-robin. The lowest index with req_valid always wins, and last_grant is unused. Starvation of higher indices is accepted.
- Undefined (default): round-robin as in Operation.

## Test plan
Setup: W=32, NUM_REQ=2, READ_LATENCY=1.
- Single write: req0 write addr 0x0000100, data 0xDEADBEEF, wb 0xF at t0. Expect req_ready[0] at t0; mmio_wb=0xF only at t0+1 with addr 0x0000100 and data 0xDEADBEEF; rsp_valid[0] at t0+2.
- Single read: req1 read addr 0x0000040, slave returns 0x12345678 one cycle after the address. Expect rsp_data=0x12345678 with rsp_valid[1] at t0+3; mmio_wb stays 0 throughout.
- Contention: req0 and req1 both held valid after reset. Grants are 0, 1, 0, 1 and never the same requester twice while the other waits.
- Back-to-back: req0 reasserts in its rsp_valid cycle. The next accept lands in the following IDLE cycle with no lost request.
- Reset mid-read: reset pulsed during WAIT. Expect no rsp_valid, all outputs zero the next cycle, and busy=0.
- MMIO_ARB_FIXED_PRIO_EN: with both requesters continuously valid, req0 is always granted and req1 never is.
